// File: rtl/pc_gen.sv
// Program-counter generator: prioritised next-PC select, fetch bubble after redirects, trap vector/epc.
// Latency: redirects take effect one cycle after being sampled; pc holds during stall and flush bubbles.
// Backpressure: stall only holds sequential advance; redirects override it. Optional: PC_GEN_MISALIGN_EN.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET  = XLEN'('h100),
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            mtvec_we,
  input  logic [XLEN-1:0] mtvec_wdata,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] badaddr,
  output logic            misalign_trap,
  output logic            halted
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state;
  logic [2:0]      flush_cnt;
  logic [XLEN-1:0] mtvec;

  logic            in_run;
  logic            ctl_req;
  logic [XLEN-1:0] ctl_tgt;
  logic [XLEN-1:0] ctl_pc;
  logic            misalign_hit;
  logic            mis_fire;
  logic            take_trap;
  logic            redirect;
  logic [XLEN-1:0] next_pc;

  assign pc_4        = pc + XLEN'(4);
  assign in_run      = (state == ST_RUN);
  assign fetch_valid = in_run && (flush_cnt == 3'd0);
  assign halted      = (state == ST_HALT);

  always_comb begin
    ctl_req = jump_valid | branch_taken;
    ctl_tgt = jump_valid ? jump_target : branch_target;
`ifdef PC_GEN_MISALIGN_EN
    misalign_hit = ctl_req && (ctl_tgt[1:0] != 2'b00);
    ctl_pc       = ctl_tgt;
`else
    misalign_hit = 1'b0;
    ctl_pc       = ctl_tgt & ~XLEN'(3);
`endif
    // A misaligned jump/branch only traps when it is the selected source.
    mis_fire  = in_run && !trap_req && !mret && misalign_hit;
    take_trap = (in_run && trap_req) || mis_fire;
    redirect  = in_run && (trap_req || mret || ctl_req);

    next_pc = pc;
    if (take_trap) begin
      next_pc = mtvec;
    end else if (in_run && mret) begin
      next_pc = epc;
    end else if (in_run && ctl_req) begin
      next_pc = ctl_pc;
    end else if (fetch_valid && !stall) begin
      // Holding through the bubble keeps the redirect target as the next fetch.
      next_pc = pc_4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BOOT;
      pc        <= RESET_VECTOR;
      mtvec     <= MTVEC_RESET;
      epc       <= '0;
      flush_cnt <= 3'd0;
    end else begin
      pc <= next_pc;
      if (take_trap) epc <= pc;
      // Trap in the same cycle reads the old mtvec through next_pc.
      if (mtvec_we) mtvec <= {mtvec_wdata[XLEN-1:2], 2'b00};

      if (redirect) begin
        flush_cnt <= 3'(FLUSH_CYCLES);
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end

      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (halt_req) state <= ST_HALT;
        ST_HALT: if (resume && !halt_req) state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifdef PC_GEN_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      badaddr       <= '0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= mis_fire;
      if (mis_fire) badaddr <= ctl_tgt;
    end
  end
`else
  assign badaddr       = '0;
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen with a queue-based scoreboard and a behavioural next-PC model.
module tb_pc_gen;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump_valid, trap_req, mret, mtvec_we, halt_req, resume;
  logic [31:0] branch_target, jump_target, mtvec_wdata;
  logic [31:0] pc, pc_4, epc, badaddr;
  logic        fetch_valid, misalign_trap, halted;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h1000), .MTVEC_RESET(32'h100), .FLUSH_CYCLES(FL)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .trap_req(trap_req), .mret(mret),
    .mtvec_we(mtvec_we), .mtvec_wdata(mtvec_wdata),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_4(pc_4), .fetch_valid(fetch_valid), .epc(epc),
    .badaddr(badaddr), .misalign_trap(misalign_trap), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        fv;
    logic        mis;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: architectural view (mode 0 boot, 1 run, 2 halt; bubble counter as an integer).
  logic [31:0] m_pc, m_mtvec, m_epc, m_bad;
  int          m_flush, m_mode;
  logic        m_mis;

  always @(posedge clk) begin
    logic [31:0] t;
    bit          redir;
    exp_t        e;
    if (reset) begin
      m_pc = 32'h1000; m_mtvec = 32'h100; m_epc = 0; m_bad = 0;
      m_flush = 0; m_mode = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      redir = 0;
      if (m_mode == 1) begin
        if (trap_req) begin
          m_epc = m_pc; m_pc = m_mtvec; redir = 1;
        end else if (mret) begin
          m_pc = m_epc; redir = 1;
        end else if (jump_valid || branch_taken) begin
          t = jump_valid ? jump_target : branch_target;
          redir = 1;
`ifdef PC_GEN_MISALIGN_EN
          if (t % 4 != 0) begin
            m_epc = m_pc; m_pc = m_mtvec; m_bad = t; m_mis = 1;
          end else m_pc = t;
`else
          m_pc = t - (t % 4);
`endif
        end else if (!stall && m_flush == 0) begin
          m_pc = m_pc + 32'd4;
        end
        if (halt_req) m_mode = 2;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (resume && !halt_req) begin
        m_mode = 1;
      end
      if (redir) m_flush = FL;
      else if (m_flush > 0) m_flush--;
      if (mtvec_we) m_mtvec = mtvec_wdata - (mtvec_wdata % 4);
    end
    e.pc = m_pc; e.epc = m_epc; e.bad = m_bad; e.mis = m_mis;
    e.fv = (m_mode == 1) && (m_flush == 0);
    e.hlt = (m_mode == 2);
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("pc", pc, e.pc);
      cmp("pc_4", pc_4, e.pc + 32'd4);
      cmp("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      cmp("epc", epc, e.epc);
      cmp("badaddr", badaddr, e.bad);
      cmp("misalign_trap", {31'd0, misalign_trap}, {31'd0, e.mis});
      cmp("halted", {31'd0, halted}, {31'd0, e.hlt});
    end
  end

  task automatic clear();
    stall = 0; branch_taken = 0; jump_valid = 0; trap_req = 0; mret = 0;
    mtvec_we = 0; halt_req = 0; resume = 0;
    branch_target = 0; jump_target = 0; mtvec_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_settle(input logic [31:0] tgt);
    jump_valid = 1; jump_target = tgt;
    tick();
    clear();
    repeat (FL) tick();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    reset = 1;
    clear();
    tick(); tick();
    reset = 0;
    cmp("boot_pc", pc, 32'h1000);
    cmp("boot_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    cmp("run_pc", pc, 32'h1000);
    cmp("run_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    cmp("adv1_pc", pc, 32'h1004);
    tick();
    cmp("adv2_pc", pc, 32'h1008);

    // Jump beats branch and overrides stall.
    branch_taken = 1; branch_target = 32'h2000;
    jump_valid = 1; jump_target = 32'h3000; stall = 1;
    tick();
    clear();
    cmp("simul_pc", pc, 32'h3000);
    cmp("simul_fv0", {31'd0, fetch_valid}, 32'd0);
    tick();
    cmp("simul_fv1", {31'd0, fetch_valid}, 32'd0);
    tick();
    cmp("simul_fv2", {31'd0, fetch_valid}, 32'd1);
    cmp("simul_hold", pc, 32'h3000);

    mtvec_we = 1; mtvec_wdata = 32'h203;
    jump_settle(32'h1010);
    trap_req = 1;
    tick();
    clear();
    cmp("trap_pc", pc, 32'h200);
    cmp("trap_epc", epc, 32'h1010);
    repeat (FL) tick();
    mret = 1;
    tick();
    clear();
    cmp("mret_pc", pc, 32'h1010);
    repeat (FL) tick();

    jump_settle(32'h1020);
    jump_valid = 1; jump_target = 32'h2002;
    tick();
    clear();
`ifdef PC_GEN_MISALIGN_EN
    cmp("mis_pc", pc, 32'h200);
    cmp("mis_epc", epc, 32'h1020);
    cmp("mis_bad", badaddr, 32'h2002);
    cmp("mis_pulse", {31'd0, misalign_trap}, 32'd1);
    tick();
    cmp("mis_pulse_end", {31'd0, misalign_trap}, 32'd0);
`else
    cmp("mask_pc", pc, 32'h2000);
    cmp("mask_mis", {31'd0, misalign_trap}, 32'd0);
    tick();
`endif
    repeat (FL) tick();

    jump_settle(32'hFFFF_FFFC);
    stall = 1;
    repeat (3) begin
      tick();
      cmp("stall_hold", pc, 32'hFFFF_FFFC);
    end
    stall = 0;
    tick();
    cmp("wrap_pc", pc, 32'h0);
    cmp("wrap_pc_4", pc_4, 32'h4);

    jump_valid = 1; jump_target = 32'h4000;
    tick();
    clear();
    halt_req = 1;
    tick();
    clear();
    trap_req = 1;
    tick();
    clear();
    cmp("halt_flag", {31'd0, halted}, 32'd1);
    cmp("halt_pc", pc, 32'h4000);
    repeat (4) tick();
    resume = 1;
    tick();
    clear();
    cmp("resume_halted", {31'd0, halted}, 32'd0);
    cmp("resume_fv", {31'd0, fetch_valid}, 32'd1);
    cmp("resume_pc", pc, 32'h4000);
    tick();
    cmp("resume_adv", pc, 32'h4004);

    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(199) == 0);
      stall         = ($urandom_range(99) < 25);
      branch_taken  = ($urandom_range(99) < 15);
      branch_target = rnd_tgt();
      jump_valid    = ($urandom_range(99) < 10);
      jump_target   = rnd_tgt();
      trap_req      = ($urandom_range(99) < 4);
      mret          = ($urandom_range(99) < 4);
      mtvec_we      = ($urandom_range(99) < 5);
      mtvec_wdata   = $urandom;
      halt_req      = ($urandom_range(99) < 5);
      resume        = ($urandom_range(99) < 30);
      tick();
    end
    reset = 0;
    clear();
    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
